// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared definitions for the instruction-fetch stage and the
//             control unit that drives its next-PC select.
//  Contents : WORD      - datapath width
//             pc_src_e  - next-PC select encodings
//             NOP_INST  - instruction injected into IF/ID on a flush
//  Revision : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

  localparam int WORD = 32;

  // Next-PC select as driven by control; 3 is reserved and treated as 0.
  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2,
    PC_RSV = 2'd3
  } pc_src_e;

  localparam logic [WORD-1:0] NOP_INST = 32'h0000_0000;

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/pc_register.sv
`default_nettype none
// ============================================================================
//  Module   : pc_register
//  Purpose  : Program-counter register with load enable and asynchronous
//             active-low reset to address zero.
//  Ports    : clk     in   clock
//             rst_n   in   async reset, active low
//             i_load  in   1 = capture i_d on the rising edge
//             i_d     in   next PC value
//             o_q     out  current PC
//  Revision : 1.0  initial release
// ============================================================================
module pc_register
  import fetch_stage_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule : pc_register
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch: holds the PC, selects the next PC, and
//             registers the fetched instruction into the IF/ID latch.
//  Ports    : clk           in   clock
//             rst_n         in   async reset, active low
//             pcSrc[1:0]    in   next-PC select (pc_src_e)
//             IF_Flush      in   squash the instruction being fetched
//             stall         in   hold PC and IF/ID
//             branchTarget  in   branch destination from ID
//             jumpTarget    in   jump destination from ID
//             instAddr      out  instruction memory address (= PC)
//             instData      in   instruction memory read data
//             IFID_inst     out  registered instruction
//             IFID_pcPlus4  out  registered PC+4 of that instruction
//             IFID_valid    out  IFID_inst is a real fetched instruction
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      pcSrc,
  input  logic            IF_Flush,
  input  logic            stall,
  input  logic [WORD-1:0] branchTarget,
  input  logic [WORD-1:0] jumpTarget,
  output logic [WORD-1:0] instAddr,
  input  logic [WORD-1:0] instData,
  output logic [WORD-1:0] IFID_inst,
  output logic [WORD-1:0] IFID_pcPlus4,
  output logic            IFID_valid
);

  logic [WORD-1:0] w_pc;
  logic [WORD-1:0] w_pc_plus4;
  logic [WORD-1:0] w_pc_next;

  logic [WORD-1:0] r_ifid_inst;
  logic [WORD-1:0] r_ifid_pc_plus4;
  logic            r_ifid_valid;

  // Wraps naturally modulo 2^32.
  assign w_pc_plus4 = w_pc + 32'd4;

  // Targets pass through untouched; alignment is the producer's concern.
  always_comb begin
    w_pc_next = w_pc_plus4;
    case (pcSrc)
      PC_BR:   w_pc_next = branchTarget;
      PC_JMP:  w_pc_next = jumpTarget;
      default: w_pc_next = w_pc_plus4;
    endcase
  end

  pc_register #(
    .WIDTH (WORD)
  ) u_pc_register (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (~stall),
    .i_d    (w_pc_next),
    .o_q    (w_pc)
  );

  // Stall outranks flush: a held slot must not be squashed, because the
  // instruction sitting in IF/ID is still waiting to be consumed by ID.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ifid_inst     <= '0;
      r_ifid_pc_plus4 <= '0;
      r_ifid_valid    <= 1'b0;
    end else if (!stall) begin
      r_ifid_inst     <= IF_Flush ? NOP_INST : instData;
      r_ifid_pc_plus4 <= w_pc_plus4;
      r_ifid_valid    <= ~IF_Flush;
    end
  end

  assign instAddr     = w_pc;
  assign IFID_inst    = r_ifid_inst;
  assign IFID_pcPlus4 = r_ifid_pc_plus4;
  assign IFID_valid   = r_ifid_valid;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage with a behavioural model of
//             the fetch pipeline and a combinational instruction memory where
//             word i holds i + 0x100.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  pcSrc;
  logic        IF_Flush;
  logic        stall;
  logic [31:0] branchTarget;
  logic [31:0] jumpTarget;
  logic [31:0] instAddr;
  logic [31:0] instData;
  logic [31:0] IFID_inst;
  logic [31:0] IFID_pcPlus4;
  logic        IFID_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [31:0] m_pc, m_inst, m_p4;
  logic        m_valid;

  fetch_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pcSrc        (pcSrc),
    .IF_Flush     (IF_Flush),
    .stall        (stall),
    .branchTarget (branchTarget),
    .jumpTarget   (jumpTarget),
    .instAddr     (instAddr),
    .instData     (instData),
    .IFID_inst    (IFID_inst),
    .IFID_pcPlus4 (IFID_pcPlus4),
    .IFID_valid   (IFID_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return (a >> 2) + 32'h100;
  endfunction

  assign instData = mem_of(instAddr);

  task automatic model_reset();
    m_pc = 32'h0; m_inst = 32'h0; m_p4 = 32'h0; m_valid = 1'b0;
  endtask

  // Drive one cycle of control, advance the model, sample 1 time unit after
  // the rising edge.
  task automatic step(input logic [1:0] src, input logic fl, input logic st,
                      input logic [31:0] bt, input logic [31:0] jt);
    pcSrc = src; IF_Flush = fl; stall = st; branchTarget = bt; jumpTarget = jt;
    @(posedge clk);
    #1;
    if (!st) begin
      m_inst  = fl ? 32'h0 : mem_of(m_pc);
      m_valid = !fl;
      m_p4    = m_pc + 32'd4;
      if (src == 2'd1)      m_pc = bt;
      else if (src == 2'd2) m_pc = jt;
      else                  m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pcSrc = 2'd0; IF_Flush = 1'b0; stall = 1'b0;
    branchTarget = 32'h0; jumpTarget = 32'h0;
    model_reset();
    #2;
    n_tests++;
    if (instAddr !== 32'h0 || IFID_inst !== 32'h0 || IFID_pcPlus4 !== 32'h0 || IFID_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%h inst=%h p4=%h v=%b, required all zero",
               instAddr, IFID_inst, IFID_pcPlus4, IFID_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr;
    for (int i = 0; i < 4; i++) begin
      step(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
      exp_addr = 32'(4 * (i + 1));
      n_tests++;
      if (instAddr !== exp_addr || IFID_inst !== 32'(32'h100 + i) ||
          IFID_pcPlus4 !== exp_addr || IFID_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL seq_fetch[%0d]: addr=%h inst=%h p4=%h v=%b, required addr=%h inst=%h p4=%h v=1",
                 i, instAddr, IFID_inst, IFID_pcPlus4, IFID_valid, exp_addr, 32'(32'h100 + i), exp_addr);
      end
    end
  endtask

  // Expects PC = 0x10 on entry.
  task automatic test_branch();
    n_tests++;
    if (instAddr !== 32'h10) begin
      n_fail++;
      $display("FAIL branch_precond: addr=%h, required 00000010", instAddr);
    end
    step(2'd1, 1'b1, 1'b0, 32'h40, 32'hDEAD_BEEC);
    n_tests++;
    if (IFID_inst !== 32'h0 || IFID_valid !== 1'b0 || IFID_pcPlus4 !== 32'h14 || instAddr !== 32'h40) begin
      n_fail++;
      $display("FAIL branch_squash: inst=%h v=%b p4=%h addr=%h, required inst=0 v=0 p4=14 addr=40",
               IFID_inst, IFID_valid, IFID_pcPlus4, instAddr);
    end
    step(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_tests++;
    if (IFID_inst !== 32'h110 || IFID_valid !== 1'b1 || IFID_pcPlus4 !== 32'h44 || instAddr !== 32'h44) begin
      n_fail++;
      $display("FAIL branch_target_fetch: inst=%h v=%b p4=%h addr=%h, required inst=110 v=1 p4=44 addr=44",
               IFID_inst, IFID_valid, IFID_pcPlus4, instAddr);
    end
  endtask

  task automatic test_jump();
    // Reach PC=0x20 via an unflushed branch, then jump.
    step(2'd1, 1'b0, 1'b0, 32'h20, 32'h0);
    n_tests++;
    if (instAddr !== 32'h20 || IFID_inst !== mem_of(32'h44) || IFID_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_precond: addr=%h inst=%h v=%b, required addr=20 inst=%h v=1",
               instAddr, IFID_inst, IFID_valid, mem_of(32'h44));
    end
    step(2'd2, 1'b1, 1'b0, 32'h0, 32'h200);
    n_tests++;
    if (instAddr !== 32'h200 || IFID_inst !== 32'h0 || IFID_valid !== 1'b0 || IFID_pcPlus4 !== 32'h24) begin
      n_fail++;
      $display("FAIL jump_redirect: addr=%h inst=%h v=%b p4=%h, required addr=200 inst=0 v=0 p4=24",
               instAddr, IFID_inst, IFID_valid, IFID_pcPlus4);
    end
    step(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_tests++;
    if (instAddr !== 32'h204 || IFID_inst !== mem_of(32'h200) || IFID_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL jump_target_fetch: addr=%h inst=%h v=%b, required addr=204 inst=%h v=1",
               instAddr, IFID_inst, IFID_valid, mem_of(32'h200));
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0, inst0, p40;
    logic        v0;
    pc0 = m_pc; inst0 = m_inst; p40 = m_p4; v0 = m_valid;
    for (int i = 0; i < 2; i++) begin
      step(2'd1, 1'b1, 1'b1, 32'h0BAD_0000, 32'h0);
      n_tests++;
      if (instAddr !== pc0 || IFID_inst !== inst0 || IFID_pcPlus4 !== p40 || IFID_valid !== v0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: addr=%h inst=%h p4=%h v=%b, required addr=%h inst=%h p4=%h v=%b",
                 i, instAddr, IFID_inst, IFID_pcPlus4, IFID_valid, pc0, inst0, p40, v0);
      end
    end
    step(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_tests++;
    if (instAddr !== pc0 + 32'd4 || IFID_inst !== mem_of(pc0) || IFID_pcPlus4 !== pc0 + 32'd4 || IFID_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release: addr=%h inst=%h p4=%h v=%b, required addr=%h inst=%h p4=%h v=1",
               instAddr, IFID_inst, IFID_pcPlus4, IFID_valid, pc0 + 32'd4, mem_of(pc0), pc0 + 32'd4);
    end
  endtask

  task automatic test_wrap();
    step(2'd2, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    n_tests++;
    if (instAddr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_precond: addr=%h, required fffffffc", instAddr);
    end
    step(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_tests++;
    if (IFID_pcPlus4 !== 32'h0 || instAddr !== 32'h0 || IFID_inst !== 32'h4000_00FF || IFID_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_pcplus4: p4=%h addr=%h inst=%h v=%b, required p4=0 addr=0 inst=400000ff v=1",
               IFID_pcPlus4, instAddr, IFID_inst, IFID_valid);
    end
  endtask

  task automatic test_async_reset();
    step(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(2'd1, 1'b1, 1'b1, 32'h80, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_tests++;
    if (instAddr !== 32'h0 || IFID_inst !== 32'h0 || IFID_pcPlus4 !== 32'h0 || IFID_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%h inst=%h p4=%h v=%b, required all zero",
               instAddr, IFID_inst, IFID_pcPlus4, IFID_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step(2'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    n_tests++;
    if (instAddr !== 32'h4 || IFID_inst !== 32'h100 || IFID_pcPlus4 !== 32'h4 || IFID_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_fetch: addr=%h inst=%h p4=%h v=%b, required addr=4 inst=100 p4=4 v=1",
               instAddr, IFID_inst, IFID_pcPlus4, IFID_valid);
    end
  endtask

  task automatic test_random();
    logic [1:0]  src;
    logic        fl, st;
    logic [31:0] bt, jt;
    for (int i = 0; i < 400; i++) begin
      src = 2'($urandom_range(0, 3));
      fl  = 1'($urandom_range(0, 3) == 0);
      st  = 1'($urandom_range(0, 4) == 0);
      bt  = $urandom();
      jt  = $urandom();
      step(src, fl, st, bt, jt);
      n_tests++;
      if (instAddr !== m_pc || IFID_inst !== m_inst || IFID_pcPlus4 !== m_p4 || IFID_valid !== m_valid) begin
        n_fail++;
        $display("FAIL random[%0d]: addr=%h inst=%h p4=%h v=%b, required addr=%h inst=%h p4=%h v=%b",
                 i, instAddr, IFID_inst, IFID_pcPlus4, IFID_valid, m_pc, m_inst, m_p4, m_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jump();
    test_stall();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL expose: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL expose: rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL expose: pcSrc  input  2  next-PC select from control (0 seq, 1 branch, 2 jump, 3 reserved).
REQ-004 SHALL expose: IF_Flush  input  1  squash the instruction currently being fetched.
REQ-005 SHALL expose: stall  input  1  hazard-unit hold; freezes PC and IF/ID.
REQ-006 SHALL expose: branchTarget  input  32  branch destination computed in ID.
REQ-007 SHALL expose: jumpTarget  input  32  jump destination computed in ID.
REQ-008 SHALL expose: instAddr  output  32  byte address to instruction memory; equals PC.
REQ-009 SHALL expose: instData  input  32  instruction memory read data, combinational from instAddr.
REQ-010 SHALL expose: IFID_inst  output  32  registered instruction to ID/control.
REQ-011 SHALL expose: IFID_pcPlus4  output  32  registered PC+4 of that instruction.
REQ-012 SHALL expose: IFID_valid  output  1  1 = IFID_inst is a real fetched instruction.

Function
REQ-013 PC SHALL be a 32-bit register; pcPlus4 = PC + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-014 Next PC SHALL be: pcSrc 0 -> pcPlus4; 1 -> branchTarget; 2 -> jumpTarget; 3 -> pcPlus4.
REQ-015 With stall=0, each rising edge SHALL load PC with next PC.
REQ-016 With stall=1, PC, IFID_inst, IFID_pcPlus4, IFID_valid SHALL hold; stall dominates pcSrc and IF_Flush.
REQ-017 With stall=0, IF_Flush=0: IF/ID SHALL capture instData, pcPlus4, valid=1.
REQ-018 With stall=0, IF_Flush=1: IF/ID SHALL capture inst=32'h00000000 (NOP), pcPlus4=pcPlus4, valid=0.
REQ-019 Redirect latency: target SHALL appear on instAddr one cycle after pcSrc asserted; exactly one slot squashed per redirect.
REQ-020 Branch/jump targets SHALL be used unmodified; low two bits not forced or checked.
REQ-021 instAddr SHALL be driven directly from the PC register, with no combinational path from any input.

Reset
REQ-022 rst_n low SHALL immediately force PC=0, IFID_inst=0, IFID_pcPlus4=0, IFID_valid=0, regardless of clk.
REQ-023 Reset mid-operation (incl. during stall or flush) SHALL discard all in-flight state; no pending redirect survives.
REQ-024 First rising edge with rst_n high and stall=0 SHALL yield IFID_inst=mem[0], IFID_pcPlus4=4, PC=4.
REQ-025 rst_n deassertion SHALL be synchronised externally; block treats it as clean.

Structure
REQ-026 Shared package SHALL hold: pcSrc encodings (PC_SEQ=0, PC_BR=1, PC_JMP=2), NOP_INST=32'h0, WORD=32.
REQ-027 Control and this block SHALL both use the package pcSrc encodings.
REQ-028 One sub-module, pc_register (32-bit, async active-low reset, load enable), SHALL hold PC; IF/ID register stays in fetch_stage.
REQ-029 No latches; all state in one clocked process per register group.

Verification
REQ-030 Reset release, stall=0, pcSrc=0, memory mem[i]=i+0x100 for 3 edges -> instAddr 0,4,8,12; IFID_inst 0x100,0x101,0x102; valid=1.
REQ-031 At PC=0x10, pcSrc=1, IF_Flush=1, branchTarget=0x40 for one edge -> IFID_inst=0, valid=0, IFID_pcPlus4=0x14; next edge fetches 0x40.
REQ-032 At PC=0x20, pcSrc=2, IF_Flush=1, jumpTarget=0x200 -> instAddr=0x200 next cycle; one NOP bubble.
REQ-033 stall=1 for 2 edges with pcSrc=1, IF_Flush=1 -> PC and IF/ID unchanged; release with pcSrc=0 -> sequential fetch resumes.
REQ-034 Force PC=0xFFFFFFFC via jump, pcSrc=0 -> IFID_pcPlus4=0x00000000, next instAddr=0.
REQ-035 Assert rst_n=0 between clock edges during stall -> all outputs 0 immediately; instAddr=0.
